// File: rtl/enc_pkg.sv
// ============================================================================
// Module  : enc_pkg
// Brief   : Shared mode encodings and index helpers for prio_enc_rr.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package enc_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;
    localparam int   MAX_N      = 256;

    // Bits at or above n are forced low so callers can truncate to n bits.
    function automatic logic [MAX_N-1:0] onehot(input int idx, input int n);
        logic [MAX_N-1:0] v;
        v = '0;
        for (int i = 0; i < MAX_N; i++) begin
            v[i] = (i == idx) && (i < n);
        end
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/prio_pick.sv
// ============================================================================
// Module  : prio_pick
// Brief   : Combinational descending-priority picker, optional wrap from start.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module prio_pick
    import enc_pkg::*;
#(
    parameter  int N     = 8,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     vec,
    input  logic [IDX_W-1:0] start,
    input  logic             rr,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    int p;

    // Candidate order is start, start-1, ... wrapping modulo N (not 2^IDX_W).
    always_comb begin
        any = 1'b0;
        idx = '0;
        p   = 0;
        for (int k = 0; k < N; k++) begin
            p = (rr == MODE_RR) ? (int'(start) - k) : (N - 1 - k);
            if (p < 0) begin
                p = p + N;
            end
            if (!any && vec[p[IDX_W-1:0]]) begin
                any = 1'b1;
                idx = p[IDX_W-1:0];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/prio_enc_rr.sv
// ============================================================================
// Module  : prio_enc_rr
// Brief   : Registered N-to-log2(N) priority encoder, request latching,
//           valid/ready output, fixed or round-robin selection.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module prio_enc_rr
    import enc_pkg::*;
#(
    parameter  int N     = 8,
    localparam int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             mode,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx,
    output logic [N-1:0]     pending,
    output logic             busy
);

    logic [N-1:0]     pend_q, pend_d;
    logic             valid_q, valid_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] last_q, last_d;

    logic             hs;
    logic             load;
    logic [N-1:0]     clr;
    logic [N-1:0]     avail;
    logic [IDX_W-1:0] start;
    logic             pick_any;
    logic [IDX_W-1:0] pick_idx;

    assign hs    = valid_q & out_ready;
    assign load  = ~valid_q | out_ready;
    assign clr   = hs ? N'(onehot(int'(idx_q), N)) : '0;
    // The index being accepted this cycle must not be re-selected.
    assign avail = pend_q & ~clr;
    assign start = (last_q == '0) ? IDX_W'(N - 1) : (last_q - IDX_W'(1));

    prio_pick #(
        .N (N)
    ) u_pick (
        .vec   (avail),
        .start (start),
        .rr    (mode == MODE_RR),
        .any   (pick_any),
        .idx   (pick_idx)
    );

    always_comb begin
        pend_d  = (pend_q & ~clr) | req;
        valid_d = valid_q;
        idx_d   = idx_q;
        last_d  = hs ? idx_q : last_q;
        if (load) begin
            valid_d = pick_any;
            if (pick_any) begin
                idx_d = pick_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q  <= '0;
            valid_q <= 1'b0;
            idx_q   <= '0;
            last_q  <= '0;
        end else begin
            pend_q  <= pend_d;
            valid_q <= valid_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
        end
    end

    assign out_valid = valid_q;
    assign out_idx   = idx_q;
    assign pending   = pend_q;
    assign busy      = (|pend_q) | valid_q;

endmodule

`default_nettype wire

// File: tb/tb_prio_enc_rr.sv
// ============================================================================
// Module  : tb_prio_enc_rr
// Brief   : Self-checking bench for prio_enc_rr at N=4 and N=5.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_prio_enc_rr;

    logic       clk;
    int         n_cmp;
    int         n_err;

    logic       a_rst_n, a_mode, a_ready, a_valid, a_busy;
    logic [3:0] a_req, a_pending;
    logic [1:0] a_idx;

    logic       b_rst_n, b_mode, b_ready, b_valid, b_busy;
    logic [4:0] b_req, b_pending;
    logic [2:0] b_idx;

    logic [1:0] qa[$];
    logic [2:0] qb[$];
    logic       sb_en_a, sb_en_b;
    logic [1:0] exp_a;
    logic [2:0] exp_b;

    prio_enc_rr #(.N(4)) dut_a (
        .clk(clk), .rst_n(a_rst_n), .req(a_req), .mode(a_mode),
        .out_ready(a_ready), .out_valid(a_valid), .out_idx(a_idx),
        .pending(a_pending), .busy(a_busy)
    );

    prio_enc_rr #(.N(5)) dut_b (
        .clk(clk), .rst_n(b_rst_n), .req(b_req), .mode(b_mode),
        .out_ready(b_ready), .out_valid(b_valid), .out_idx(b_idx),
        .pending(b_pending), .busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs only change just after a rising edge, so valid&ready seen on the
    // falling edge is exactly the handshake of the next rising edge.
    always @(negedge clk) begin
        if (sb_en_a && a_rst_n && a_valid && a_ready) begin
            n_cmp++;
            if (qa.size() == 0) begin
                n_err++;
                $display("FAIL sb_a_extra: got grant %0d expected none", a_idx);
            end else begin
                exp_a = qa.pop_front();
                if (a_idx !== exp_a) begin
                    n_err++;
                    $display("FAIL sb_a_grant: got %0d expected %0d", a_idx, exp_a);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (sb_en_b && b_rst_n && b_valid && b_ready) begin
            n_cmp++;
            if (b_idx >= 3'd5) begin
                n_err++;
                $display("FAIL sb_b_range: got %0d expected below 5", b_idx);
            end
            n_cmp++;
            if (qb.size() == 0) begin
                n_err++;
                $display("FAIL sb_b_extra: got grant %0d expected none", b_idx);
            end else begin
                exp_b = qb.pop_front();
                if (b_idx !== exp_b) begin
                    n_err++;
                    $display("FAIL sb_b_grant: got %0d expected %0d", b_idx, exp_b);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        a_rst_n = 1'b0; b_rst_n = 1'b0;
        repeat (2) step();
        n_cmp++;
        if ({a_valid, a_idx, a_pending, a_busy} !== 8'b0) begin
            n_err++;
            $display("FAIL reset_a: got v=%b i=%0d p=%b b=%b expected all 0", a_valid, a_idx, a_pending, a_busy);
        end
        n_cmp++;
        if ({b_valid, b_idx, b_pending, b_busy} !== 10'b0) begin
            n_err++;
            $display("FAIL reset_b: got v=%b i=%0d p=%b b=%b expected all 0", b_valid, b_idx, b_pending, b_busy);
        end
        @(negedge clk);
        a_rst_n = 1'b1; b_rst_n = 1'b1;
        step();
        n_cmp++;
        if ({a_valid, a_pending, a_busy} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_idle: got v=%b p=%b b=%b expected all 0", a_valid, a_pending, a_busy);
        end
    endtask

    task automatic test_fixed();
        a_mode = 1'b0; a_ready = 1'b1;
        step();
        a_req = 4'b0110;
        step();
        a_req = 4'b0000;
        n_cmp++;
        if (a_pending !== 4'b0110 || a_valid !== 1'b0) begin
            n_err++;
            $display("FAIL fixed_t1: got p=%b v=%b expected p=0110 v=0", a_pending, a_valid);
        end
        step();
        n_cmp++;
        if (a_valid !== 1'b1 || a_idx !== 2'd2) begin
            n_err++;
            $display("FAIL fixed_t2: got v=%b i=%0d expected v=1 i=2", a_valid, a_idx);
        end
        step();
        n_cmp++;
        if (a_valid !== 1'b1 || a_idx !== 2'd1 || a_pending !== 4'b0010) begin
            n_err++;
            $display("FAIL fixed_t3: got v=%b i=%0d p=%b expected v=1 i=1 p=0010", a_valid, a_idx, a_pending);
        end
        step();
        n_cmp++;
        if (a_valid !== 1'b0 || a_pending !== 4'b0000 || a_busy !== 1'b0) begin
            n_err++;
            $display("FAIL fixed_t4: got v=%b p=%b b=%b expected all 0", a_valid, a_pending, a_busy);
        end
    endtask

    task automatic test_backpressure();
        a_mode = 1'b0; a_ready = 1'b0;
        step();
        a_req = 4'b1000;
        step();
        a_req = 4'b0001;
        n_cmp++;
        if (a_pending !== 4'b1000) begin
            n_err++;
            $display("FAIL bp_pend1: got %b expected 1000", a_pending);
        end
        step();
        a_req = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (a_valid !== 1'b1 || a_idx !== 2'd3 || a_pending !== 4'b1001) begin
                n_err++;
                $display("FAIL bp_hold%0d: got v=%b i=%0d p=%b expected v=1 i=3 p=1001", i, a_valid, a_idx, a_pending);
            end
            step();
        end
        qa.push_back(2'd3);
        qa.push_back(2'd0);
        sb_en_a = 1'b1;
        a_ready = 1'b1;
        for (int c = 0; c < 20 && qa.size() != 0; c++) step();
        n_cmp++;
        if (qa.size() != 0) begin
            n_err++;
            $display("FAIL bp_drain: got %0d grants outstanding expected 0", qa.size());
        end
        n_cmp++;
        if (a_valid !== 1'b0 || a_pending !== 4'b0000) begin
            n_err++;
            $display("FAIL bp_idle: got v=%b p=%b expected v=0 p=0000", a_valid, a_pending);
        end
        sb_en_a = 1'b0;
    endtask

    task automatic test_set_wins();
        a_mode = 1'b0; a_ready = 1'b1;
        step();
        a_req = 4'b0100;
        step();
        a_req = 4'b0000;
        step();
        n_cmp++;
        if (a_valid !== 1'b1 || a_idx !== 2'd2) begin
            n_err++;
            $display("FAIL sw_first: got v=%b i=%0d expected v=1 i=2", a_valid, a_idx);
        end
        a_req = 4'b0100;
        step();
        a_req = 4'b0000;
        n_cmp++;
        if (a_pending !== 4'b0100 || a_valid !== 1'b0) begin
            n_err++;
            $display("FAIL sw_kept: got p=%b v=%b expected p=0100 v=0", a_pending, a_valid);
        end
        step();
        n_cmp++;
        if (a_valid !== 1'b1 || a_idx !== 2'd2) begin
            n_err++;
            $display("FAIL sw_regrant: got v=%b i=%0d expected v=1 i=2", a_valid, a_idx);
        end
        step();
        n_cmp++;
        if (a_valid !== 1'b0 || a_pending !== 4'b0000) begin
            n_err++;
            $display("FAIL sw_idle: got v=%b p=%b expected v=0 p=0000", a_valid, a_pending);
        end
    endtask

    task automatic test_mode_switch();
        a_mode = 1'b1; a_ready = 1'b1;
        qa.push_back(2'd3);
        sb_en_a = 1'b1;
        step();
        a_req = 4'b1000;
        step();
        a_req = 4'b0000;
        for (int c = 0; c < 20 && qa.size() != 0; c++) step();
        n_cmp++;
        if (qa.size() != 0 || a_valid !== 1'b0) begin
            n_err++;
            $display("FAIL ms_rr: got outstanding=%0d v=%b expected 0 and v=0", qa.size(), a_valid);
        end
        // Round-robin would now favour index 1; fixed mode must pick 3.
        a_mode = 1'b0;
        qa.push_back(2'd3);
        qa.push_back(2'd1);
        a_req = 4'b1010;
        step();
        a_req = 4'b0000;
        for (int c = 0; c < 20 && qa.size() != 0; c++) step();
        n_cmp++;
        if (qa.size() != 0 || a_valid !== 1'b0 || a_pending !== 4'b0000) begin
            n_err++;
            $display("FAIL ms_fixed: got outstanding=%0d v=%b p=%b expected 0 v=0 p=0000", qa.size(), a_valid, a_pending);
        end
        sb_en_a = 1'b0;
    endtask

    task automatic test_async_reset();
        a_mode = 1'b1; a_ready = 1'b1;
        a_req = 4'b1111;
        repeat (3) step();
        n_cmp++;
        if (a_valid !== 1'b1) begin
            n_err++;
            $display("FAIL ar_busy: got v=%b expected 1", a_valid);
        end
        #2;
        a_rst_n = 1'b0;
        #1;
        n_cmp++;
        if (a_valid !== 1'b0 || a_pending !== 4'b0000 || a_busy !== 1'b0 || a_idx !== 2'd0) begin
            n_err++;
            $display("FAIL ar_immediate: got v=%b p=%b b=%b i=%0d expected all 0", a_valid, a_pending, a_busy, a_idx);
        end
        step();
        n_cmp++;
        if (a_valid !== 1'b0 || a_pending !== 4'b0000) begin
            n_err++;
            $display("FAIL ar_held: got v=%b p=%b expected v=0 p=0000", a_valid, a_pending);
        end
        qa.push_back(2'd3);
        qa.push_back(2'd2);
        qa.push_back(2'd1);
        qa.push_back(2'd0);
        qa.push_back(2'd3);
        sb_en_a = 1'b1;
        @(negedge clk);
        a_rst_n = 1'b1;
        for (int c = 0; c < 30 && qa.size() != 0; c++) step();
        n_cmp++;
        if (qa.size() != 0) begin
            n_err++;
            $display("FAIL ar_rr_order: got %0d grants outstanding expected 0", qa.size());
        end
        sb_en_a = 1'b0;
        a_req = 4'b0000;
    endtask

    task automatic test_round_robin();
        b_mode = 1'b1; b_ready = 1'b1;
        for (int r = 0; r < 2; r++) begin
            for (int i = 4; i >= 0; i--) qb.push_back(3'(i));
        end
        sb_en_b = 1'b1;
        step();
        b_req = 5'b11111;
        for (int c = 0; c < 40 && qb.size() != 0; c++) step();
        n_cmp++;
        if (qb.size() != 0) begin
            n_err++;
            $display("FAIL rr_seq: got %0d grants outstanding expected 0", qb.size());
        end
        sb_en_b = 1'b0;
        b_req = 5'b00000;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        n_cmp = 0; n_err = 0;
        sb_en_a = 1'b0; sb_en_b = 1'b0;
        a_rst_n = 1'b0; a_req = '0; a_mode = 1'b0; a_ready = 1'b0;
        b_rst_n = 1'b0; b_req = '0; b_mode = 1'b0; b_ready = 1'b0;
        test_reset();
        test_fixed();
        test_backpressure();
        test_set_wins();
        test_mode_switch();
        test_async_reset();
        test_round_robin();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/prio_enc_rr.md
# prio_enc_rr

Registered, parametrised N-to-log2(N) priority encoder with request latching, a valid/ready output handshake, and a runtime-selectable fixed-priority or round-robin mode. It is the successor to the team's combinational 4-to-2 encoder. Requests are captured into a pending vector and served one index per handshake, with the highest index winning in fixed mode. It sits between interrupt or request sources and a single consumer that services one index at a time.

## Interface
- N, default 8: number of request lines; legal range 2..256; need not be a power of two.
- IDX_W, default $clog2(N): index width; derived, never overridden.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  N  request pulses or levels; bit i is OR-ed into pending[i] each cycle.
- mode  in  1  0 = fixed priority, 1 = round-robin; sampled whenever a new selection loads.
- out_ready  in  1  consumer accepts out_idx this cycle.
- out_valid  out  1  out_idx holds a granted request.
- out_idx  out  IDX_W  granted index.
- pending  out  N  current latched request vector, registered.
- busy  out  1  |pending | out_valid.

## Operation
- pend_q update on each edge: pend_q <= (pend_q & ~clr) | req.
  - clr is onehot(out_idx) when out_valid & out_ready, else 0.
  - If req[i] and clr[i] occur in the same cycle, the set wins and index i is re-requested.
- Selection is made from avail = pend_q & ~clr, i.e. the index being accepted this cycle is excluded.
- Output register loads when !out_valid | out_ready:
  - out_valid <= |avail.
  - out_idx <= pick(avail); when avail is 0, out_idx holds its previous value.
- While out_valid & !out_ready, out_idx and out_valid are frozen. Pending bits continue to accumulate.
- Fixed mode (mode=0): pick = the highest set index.
- Round-robin mode (mode=1): search starts at (last_q − 1) mod N and descends, wrapping from 0 to N−1.
  - last_q <= out_idx on every accepted handshake, in both modes.
  - Reset value of last_q is 0, so the first round-robin search starts at N−1 and matches fixed mode.
- Index arithmetic is modulo N, not 2^IDX_W. Index values ≥ N are never produced.
- A mode change takes effect at the next output load. An already-presented out_idx is never altered.

## Timing
- Reset, asynchronous: pend_q=0, out_valid=0, out_idx=0, last_q=0, so pending=0 and busy=0.
- Reset asserted mid-operation discards all pending requests and any presented grant immediately.
- Latency, idle path: req[i] high in cycle t gives pending[i]=1 at t+1 and out_valid=1, out_idx=i at t+2.
- Back-to-back service: with out_ready held high and pend_q holding k bits, exactly k consecutive handshakes occur and out_valid drops on the next cycle.
- Throughput is one grant per cycle. There are no bubbles while avail is non-zero.
- A request for the currently presented, unaccepted index is absorbed (it is already pending). No duplicate grant results.
- All bits set with round-robin mode and ready held high: every index is granted exactly once per N cycles.

## Structure
- Shared package enc_pkg:
  - MODE_FIXED = 1'b0 and MODE_RR = 1'b1.
  - onehot(idx, N) function.
- Sub-module prio_pick, purely combinational, with parameter N.
  - Inputs: vec[N], start[IDX_W], rr.
  - Outputs: any and idx.
  - Behaviour: descending search from start with wrap when rr=1; from N−1 without wrap when rr=0.
- The top level holds pend_q, the output register, and last_q.

## Test plan
- Fixed mode, N=4: reset, then drive req=4'b0110 for one cycle with out_ready=1.
  - Required response: out_idx=2 at t+2, out_idx=1 at t+3, out_valid=0 at t+4.
- Backpressure, N=4: hold out_ready=0 and apply req=4'b1000 followed by req=4'b0001.
  - Required response: out_idx stays 3 with pending=4'b1001 throughout.
  - After out_ready=1: out_idx goes 3 then 0.
- Round-robin, N=5: hold req=5'b11111 and out_ready=1 with mode=1.
  - Required grant sequence: 4,3,2,1,0,4,3,…, each index exactly once per 5 cycles, never ≥5.
- Set wins clear: while out_idx=2 is being accepted, assert req[2] in the same cycle.
  - Required response: pending[2] stays 1 and index 2 is granted again later.
- Mode switch: in round-robin mode after granting 3, switch to fixed mode with pending=4'b1010 at N=4.
  - Required response: the next grant is 3, not 1.
- Async reset: assert rst_n=0 mid-burst, between clock edges.
  - Required response: out_valid=0 and pending=0 immediately.
  - After release: first round-robin grant follows the N−1-first order.
